chime_sequencer: RTL and testbench
==================================

// Module: chime_sequencer
// PURPOSE
//  Parametrised hourly chime engine for the clock datapath. Sits between the time counters and the speaker pin.
//  On each top-of-hour, or on a manual bell request, it plays a programmable melody held in internal RAM.
//  It then strikes the hour N times with a fixed tone; a built-in square-wave generator drives the speaker.
//  Generalises the fixed-table chime: programmable melody depth, tone width, beat timing and 12/24-h strike modes.
// PARAMETERS
//  HP_W       20           width of a note half-period (clk cycles); 0 = rest
//  MEL_LEN    19           melody RAM depth (notes), >=1
//  AW         5            melody address width, 2**AW >= MEL_LEN
//  BEAT_CYC   100_000_000  clk cycles per melody note and per strike tone
//  GAP_CYC    100_000_000  silent clk cycles after each strike
//  STRIKE_HP  20000        half-period of the strike tone
//  MODE_24H   0            0: strike hour mod 12 (0 -> 12); 1: strike hour (0 -> 24)
// PORTS
//  clk        in   1     system clock
//  rst        in   1     asynchronous, active-high reset
//  en         in   1     chime enable; low aborts any sequence
//  bell       in   1     manual trigger, one-cycle pulse
//  mode       in   2     00 strike only, 01 melody only, 1x melody then strike
//  hour       in   6     current hour, 0..23
//  min        in   6     current minute
//  sec        in   6     current second
//  mel_we     in   1     melody RAM write strobe
//  mel_addr   in   AW    melody RAM write address; writes with addr >= MEL_LEN are ignored
//  mel_data   in   HP_W  melody RAM write data (half-period)
//  busy       out  1     high while not IDLE
//  speak      out  1     square-wave speaker drive
// BEHAVIOUR
//  Reset (async): state=IDLE; busy=0; speak=0; all counters=0; top_q=0. Melody RAM is not cleared.
//  Top-of-hour: top = (min==0 && sec==0), registered to top_q. The start event is top & ~top_q.
//   It fires once per hour, even while top is held for a whole second.
//  Start (IDLE only, en=1): start event or bell -> latch hour, compute N; next state MELODY if mode!=00, else STRIKE_ON.
//   busy rises the cycle after the trigger. Triggers while busy are ignored, not queued.
//  N: MODE_24H=0 -> hour%12, with 0 -> 12. MODE_24H=1 -> hour, with 0 -> 24. hour>23 -> N=0.
//  States: IDLE, MELODY, STRIKE_ON, STRIKE_GAP.
//   MELODY: idx 0..MEL_LEN-1. Each note lasts exactly BEAT_CYC cycles. hp=mel[idx] is latched at beat start.
//    After the last note: mode==01 -> IDLE; otherwise STRIKE_ON, or IDLE if N==0.
//   STRIKE_ON: hp=STRIKE_HP for BEAT_CYC cycles, then STRIKE_GAP.
//   STRIKE_GAP: speak=0 for GAP_CYC cycles; strike count k++. k==N -> IDLE, else STRIKE_ON.
//   mode==00 with N==0: the trigger is ignored and busy stays 0.
//  Tone gen: at each beat start, speak=0 and the tone counter=0.
//   Then the tone counter counts 0..hp-1 and speak toggles on wrap. hp==0 -> speak held 0; hp==1 -> toggles every cycle.
//  RAM writes: allowed any time; synchronous write. A write to the playing index affects only that note's next play.
//  en low in any state: IDLE next cycle; speak=0, busy=0; strike and melody counters cleared.
//  Beat/gap counters are 32 bit and wrap-safe. BEAT_CYC and GAP_CYC >= 1.
//  Simultaneous bell and top-of-hour: a single sequence starts.
//  speak and busy are registered outputs; no combinational input-to-output path.
// TESTING (params: MEL_LEN=4, AW=2, BEAT_CYC=8, GAP_CYC=8, STRIKE_HP=2)
//  Reset mid-strike -> speak=0, busy=0 immediately; a subsequent bell restarts from the first note.
//  mel={3,0,1,2}, mode=01, bell -> speak toggles every 3 cycles for 8 cycles, is low for 8 cycles,
//   toggles every cycle for 8 cycles, toggles every 2 cycles for 8 cycles; busy then drops.
//  mode=00, hour=15, min/sec step to 0:00 -> 3 strikes of 8 tone + 8 gap cycles, busy=1 for 48 cycles.
//   Holding sec=0 for 100 cycles gives no retrigger.
//  hour=0: MODE_24H=0 -> 12 strikes; MODE_24H=1 -> 24 strikes. hour=25, mode=00 -> busy never rises.
//  en dropped during strike 2 -> IDLE next cycle, speak=0; bell while busy -> no effect, strike count unchanged.
//  mode=10, hour=13 -> melody (4 beats), then exactly 1 strike, then IDLE; mel_we to addr 3 mid-melody alters only later plays.

Source files
------------

// File: rtl/chime_sequencer.sv
// chime_sequencer: hourly/bell-triggered melody player plus hour striker with square-wave speaker drive
module chime_sequencer #(
  parameter int HP_W      = 20,
  parameter int MEL_LEN   = 19,
  parameter int AW        = 5,
  parameter int BEAT_CYC  = 100_000_000,
  parameter int GAP_CYC   = 100_000_000,
  parameter int STRIKE_HP = 20000,
  parameter int MODE_24H  = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            bell,
  input  logic [1:0]      mode,
  input  logic [5:0]      hour,
  input  logic [5:0]      min,
  input  logic [5:0]      sec,
  input  logic            mel_we,
  input  logic [AW-1:0]   mel_addr,
  input  logic [HP_W-1:0] mel_data,
  output logic            busy,
  output logic            speak
);
  localparam logic [1:0] IDLE = 2'd0, MELODY = 2'd1, STRIKE_ON = 2'd2, STRIKE_GAP = 2'd3;
  localparam logic [31:0] BEAT_END = 32'(BEAT_CYC - 1);
  localparam logic [31:0] GAP_END = 32'(GAP_CYC - 1);
  localparam logic [AW-1:0] LAST = AW'(MEL_LEN - 1);
  localparam logic [HP_W-1:0] SHP = HP_W'(STRIKE_HP);
  logic [HP_W-1:0] mel [MEL_LEN];
  logic [1:0] state, nxt;
  logic [AW-1:0] idx;
  logic [5:0] k, n, n_calc, h12;
  logic [31:0] cnt;
  logic [HP_W-1:0] tone, hp, nhp;
  logic top, top_q, start, trig, do_strike, bs;
  assign top = min == 6'd0 && sec == 6'd0;
  assign start = top & ~top_q;
  assign h12 = hour % 6'd12;
  assign n_calc = hour > 6'd23 ? 6'd0 : MODE_24H != 0 ? (hour == 6'd0 ? 6'd24 : hour) : (h12 == 6'd0 ? 6'd12 : h12);
  assign trig = (start | bell) & ~(mode == 2'b00 && n_calc == 6'd0);
  assign busy = state != IDLE;
  always_ff @(posedge clk)
    if (mel_we && 32'(mel_addr) < MEL_LEN) mel[mel_addr] <= mel_data;
  // bs marks a beat boundary: counters and speaker restart with the newly latched half-period
  always_comb begin
    nxt = state;
    bs = 1'b0;
    nhp = hp;
    case (state)
      IDLE: begin
        bs = 1'b1;
        nhp = '0;
        if (trig) begin
          nxt = mode != 2'b00 ? MELODY : STRIKE_ON;
          nhp = mode != 2'b00 ? mel[0] : SHP;
        end
      end
      MELODY:
        if (cnt == BEAT_END) begin
          bs = 1'b1;
          nxt = idx != LAST ? MELODY : (do_strike && n != 6'd0) ? STRIKE_ON : IDLE;
          nhp = idx != LAST ? mel[idx + AW'(1)] : nxt == STRIKE_ON ? SHP : '0;
        end
      STRIKE_ON:
        if (cnt == BEAT_END) begin
          bs = 1'b1;
          nxt = STRIKE_GAP;
          nhp = '0;
        end
      default:
        if (cnt == GAP_END) begin
          bs = 1'b1;
          nxt = 6'(k + 6'd1) == n ? IDLE : STRIKE_ON;
          nhp = nxt == IDLE ? '0 : SHP;
        end
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      k <= '0;
      n <= '0;
      cnt <= '0;
      tone <= '0;
      hp <= '0;
      speak <= 1'b0;
      top_q <= 1'b0;
      do_strike <= 1'b0;
    end else begin
      top_q <= top;
      if (!en) begin
        state <= IDLE;
        idx <= '0;
        k <= '0;
        cnt <= '0;
        tone <= '0;
        hp <= '0;
        speak <= 1'b0;
      end else begin
        state <= nxt;
        if (state == IDLE && trig) begin
          n <= n_calc;
          do_strike <= mode[1];
          idx <= '0;
          k <= '0;
        end
        if (state == MELODY && bs) idx <= idx == LAST ? '0 : idx + AW'(1);
        if (state == STRIKE_GAP && bs) k <= nxt == IDLE ? '0 : k + 6'd1;
        if (bs) begin
          cnt <= '0;
          tone <= '0;
          hp <= nhp;
          speak <= 1'b0;
        end else begin
          cnt <= cnt + 32'd1;
          if (hp != '0) begin
            tone <= tone == hp - HP_W'(1) ? '0 : tone + HP_W'(1);
            speak <= tone == hp - HP_W'(1) ? ~speak : speak;
          end
        end
      end
    end
endmodule

// File: tb/tb_chime_sequencer.sv
// tb_chime_sequencer: directed scoreboard bench for melody, strike, trigger and abort behaviour
module tb_chime_sequencer;
  logic clk = 1'b0, rst = 1'b1, en = 1'b1, en24 = 1'b0, bell = 1'b0, mel_we = 1'b0, sel = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [5:0] hour = 6'd0, min = 6'd59, sec = 6'd59;
  logic [1:0] mel_addr = 2'd0;
  logic [19:0] mel_data = 20'd0;
  logic busy, speak, busy24, speak24, mb, ms;
  int checks = 0, failures = 0;
  logic [1:0] q [$];

  chime_sequencer #(.MEL_LEN(4), .AW(2), .BEAT_CYC(8), .GAP_CYC(8), .STRIKE_HP(2), .MODE_24H(0)) dut (
    .clk(clk), .rst(rst), .en(en), .bell(bell), .mode(mode), .hour(hour), .min(min), .sec(sec),
    .mel_we(mel_we), .mel_addr(mel_addr), .mel_data(mel_data), .busy(busy), .speak(speak));
  chime_sequencer #(.MEL_LEN(4), .AW(2), .BEAT_CYC(8), .GAP_CYC(8), .STRIKE_HP(2), .MODE_24H(1)) dut24 (
    .clk(clk), .rst(rst), .en(en24), .bell(bell), .mode(mode), .hour(hour), .min(min), .sec(sec),
    .mel_we(mel_we), .mel_addr(mel_addr), .mel_data(mel_data), .busy(busy24), .speak(speak24));

  assign mb = sel ? busy24 : busy;
  assign ms = sel ? speak24 : speak;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic push_beat(input int hp, input int len);
    for (int j = 0; j < len; j++) q.push_back({1'b1, hp == 0 ? 1'b0 : 1'((j / hp) % 2)});
  endtask

  task automatic push_strikes(input int n);
    repeat (n) begin
      push_beat(2, 8);
      push_beat(0, 8);
    end
  endtask

  task automatic push_melody(input int a, input int b, input int c, input int d);
    push_beat(a, 8);
    push_beat(b, 8);
    push_beat(c, 8);
    push_beat(d, 8);
  endtask

  task automatic drain(input int n);
    logic [1:0] e;
    for (int i = 0; i < n; i++) begin
      e = q.pop_front();
      check("seq_busy", mb, e[1]);
      check("seq_speak", ms, e[0]);
      @(negedge clk);
    end
  endtask

  task automatic drain_idle();
    drain(q.size());
    check("end_busy", mb, 1'b0);
    check("end_speak", ms, 1'b0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [19:0] d);
    mel_addr = a;
    mel_data = d;
    mel_we = 1'b1;
    @(negedge clk);
    mel_we = 1'b0;
  endtask

  task automatic ring();
    bell = 1'b1;
    @(negedge clk);
    bell = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_speak", speak, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    wr(2'd0, 20'd3);
    wr(2'd1, 20'd0);
    wr(2'd2, 20'd1);
    wr(2'd3, 20'd2);
    // melody only: 3,0,1,2 half-periods
    mode = 2'b01;
    ring();
    push_melody(3, 0, 1, 2);
    drain_idle();
    // top-of-hour strikes, hour 15 -> 3
    mode = 2'b00;
    hour = 6'd15;
    @(negedge clk);
    min = 6'd0;
    sec = 6'd0;
    @(negedge clk);
    push_strikes(3);
    drain_idle();
    for (int i = 0; i < 100; i++) begin
      check("no_retrig", busy, 1'b0);
      @(negedge clk);
    end
    min = 6'd59;
    sec = 6'd59;
    @(negedge clk);
    // hour 0 in 12h mode -> 12 strikes
    hour = 6'd0;
    ring();
    push_strikes(12);
    drain_idle();
    // hour 0 in 24h mode -> 24 strikes
    en = 1'b0;
    en24 = 1'b1;
    sel = 1'b1;
    ring();
    push_strikes(24);
    drain_idle();
    sel = 1'b0;
    en24 = 1'b0;
    en = 1'b1;
    @(negedge clk);
    // out-of-range hour ignored in strike-only mode
    hour = 6'd25;
    ring();
    for (int i = 0; i < 20; i++) begin
      check("h25_busy", busy, 1'b0);
      @(negedge clk);
    end
    // en dropped during strike 2
    hour = 6'd3;
    ring();
    push_strikes(3);
    drain(19);
    check("pre_abort_speak", speak, 1'b1);
    en = 1'b0;
    q.delete();
    @(negedge clk);
    check("abort_busy", busy, 1'b0);
    check("abort_speak", speak, 1'b0);
    en = 1'b1;
    @(negedge clk);
    check("abort_stay", busy, 1'b0);
    // bell while busy is ignored
    hour = 6'd2;
    ring();
    push_strikes(2);
    drain(5);
    bell = 1'b1;
    drain(1);
    bell = 1'b0;
    drain_idle();
    repeat (3) @(negedge clk);
    check("no_queue", busy, 1'b0);
    // simultaneous bell and top-of-hour -> one sequence
    hour = 6'd1;
    min = 6'd0;
    sec = 6'd0;
    bell = 1'b1;
    @(negedge clk);
    bell = 1'b0;
    push_strikes(1);
    drain_idle();
    min = 6'd59;
    sec = 6'd59;
    @(negedge clk);
    // async reset mid-strike
    hour = 6'd5;
    ring();
    push_strikes(5);
    drain(19);
    rst = 1'b1;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_speak", speak, 1'b0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    mode = 2'b01;
    ring();
    push_melody(3, 0, 1, 2);
    drain_idle();
    // melody then strike; rewrite of the playing note applies next time
    mode = 2'b10;
    hour = 6'd13;
    ring();
    push_melody(3, 0, 1, 2);
    push_strikes(1);
    drain(26);
    mel_addr = 2'd3;
    mel_data = 20'd1;
    mel_we = 1'b1;
    drain(1);
    mel_we = 1'b0;
    drain_idle();
    mode = 2'b01;
    ring();
    push_melody(3, 0, 1, 1);
    drain_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
